// File: rtl/a2d_sweep_ctrl.sv
// Sequences the shared SPI A2D master through left load cell, right load cell and battery.
// Optional battery decimation (1 in 8 sweeps) is enabled with `define A2D_BATT_DECIM_EN.
module a2d_sweep_ctrl #(
    parameter logic [2:0]  LFT_CH  = 3'd0,
    parameter logic [2:0]  RGHT_CH = 3'd4,
    parameter logic [2:0]  BATT_CH = 3'd5,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle, StCmd, StWaitC, StGapC, StRd, StWaitR, StGapN, StFin
    } state_e;

    // GAP states last GAP_CYC clocks: load N-1 and leave when the count reaches zero
    localparam logic [3:0] GapLoad = 4'(GAP_CYC - 1);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  gap_q, gap_d;
    logic        pend_q, pend_d;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cnv_q, cnv_d;
    logic        busy_q, busy_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic [11:0] batt_q, batt_d;
`ifdef A2D_BATT_DECIM_EN
    logic [2:0]  swp_q, swp_d;
`endif

    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:12];

    function automatic logic [15:0] chan_cmd(input logic [1:0] idx);
        logic [2:0] ch;
        case (idx)
            2'd0:    ch = LFT_CH;
            2'd1:    ch = RGHT_CH;
            default: ch = BATT_CH;
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        batt_d  = batt_q;
        cmd_d   = cmd_q;
        pend_d  = pend_q | (nxt & (state_q != StIdle));
`ifdef A2D_BATT_DECIM_EN
        swp_d   = swp_q;
`endif

        case (state_q)
            StIdle: begin
                if (nxt) begin
                    idx_d   = 2'd0;
                    state_d = StCmd;
                end
            end
            StCmd: state_d = StWaitC;
            StWaitC: begin
                if (done) begin
                    gap_d   = GapLoad;
                    state_d = StGapC;
                end
            end
            StGapC: begin
                if (gap_q == 4'd0) state_d = StRd;
                else               gap_d   = gap_q - 4'd1;
            end
            StRd: state_d = StWaitR;
            StWaitR: begin
                if (done) begin
                    case (idx_q)
                        2'd0:    lft_d  = rd_data[11:0];
                        2'd1:    rght_d = rd_data[11:0];
                        default: batt_d = rd_data[11:0];
                    endcase
                    if (idx_q == 2'd2) begin
                        state_d = StFin;
`ifdef A2D_BATT_DECIM_EN
                    end else if ((idx_q == 2'd1) && (swp_q != 3'd0)) begin
                        state_d = StFin;
`endif
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        gap_d   = GapLoad;
                        state_d = StGapN;
                    end
                end
            end
            StGapN: begin
                if (gap_q == 4'd0) state_d = StCmd;
                else               gap_d   = gap_q - 4'd1;
            end
            StFin: begin
`ifdef A2D_BATT_DECIM_EN
                swp_d = swp_q + 3'd1;
`endif
                // A nxt landing in FIN counts as pending so the next sweep starts at once
                pend_d = 1'b0;
                if (pend_q || nxt) begin
                    idx_d   = 2'd0;
                    state_d = StCmd;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered so they line up with the state being entered
        wrt_d  = (state_d == StCmd) || (state_d == StRd);
        cnv_d  = (state_d == StFin);
        busy_d = (state_d != StIdle);
        if (state_d == StCmd)     cmd_d = chan_cmd(idx_d);
        else if (state_d == StRd) cmd_d = 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            gap_q   <= 4'd0;
            pend_q  <= 1'b0;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            cnv_q   <= 1'b0;
            busy_q  <= 1'b0;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            batt_q  <= 12'h000;
`ifdef A2D_BATT_DECIM_EN
            swp_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            cnv_q   <= cnv_d;
            busy_q  <= busy_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            batt_q  <= batt_d;
`ifdef A2D_BATT_DECIM_EN
            swp_q   <= swp_d;
`endif
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign cnv_cmplt = cnv_q;
    assign busy      = busy_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign batt      = batt_q;

endmodule

// File: tb/tb_a2d_sweep_ctrl.sv
// Scoreboard bench for a2d_sweep_ctrl: expected commands/results queued per sweep,
// checked as the SPI model sees wrt and as cnv_cmplt pulses.
module tb_a2d_sweep_ctrl;

    localparam int GapCyc = 2;
`ifdef A2D_BATT_DECIM_EN
    localparam bit Decim = 1'b1;
`else
    localparam bit Decim = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        cnv_cmplt, busy;

    a2d_sweep_ctrl #(.GAP_CYC(GapCyc)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .wrt       (wrt),
        .cmd       (cmd),
        .done      (done),
        .rd_data   (rd_data),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] exp_cmd_q[$];
    logic [15:0] resp_q[$];
    logic [35:0] exp_res_q[$];
    int          sw_cnt = 0;
    logic [11:0] model_batt = 12'h000;
    int          cnv_cnt = 0;
    int          wrt_cnt = 0;
    int          cyc = 0;
    int          last_done_cyc = -1;
    bit          fin_since_done = 1'b1;
    bit          in_flight = 1'b0;
    int          lat = 0;
    bit          spur_req = 1'b0;

    // Queue one sweep; complete=0 leaves the final read unanswered
    task automatic push_sweep(input logic [11:0] l, input logic [11:0] r, input logic [11:0] b,
                              input bit complete);
        bit do_b;
        do_b = !Decim || ((sw_cnt % 8) == 0);
        exp_cmd_q.push_back(16'h0000); exp_cmd_q.push_back(16'h0000);
        exp_cmd_q.push_back(16'h2000); exp_cmd_q.push_back(16'h0000);
        resp_q.push_back(16'h5A5A); resp_q.push_back({4'hA, l}); resp_q.push_back(16'h5A5A);
        if (do_b) begin
            exp_cmd_q.push_back(16'h2800); exp_cmd_q.push_back(16'h0000);
            resp_q.push_back({4'hB, r}); resp_q.push_back(16'h5A5A);
            if (complete) begin
                resp_q.push_back({4'hC, b});
                model_batt = b;
            end
        end else if (complete) begin
            resp_q.push_back({4'hB, r});
        end
        if (complete) begin
            exp_res_q.push_back({l, r, model_batt});
            sw_cnt++;
        end
    endtask

    task automatic pulse_nxt();
        @(posedge clk); #1 nxt = 1'b1;
        @(posedge clk); #1 nxt = 1'b0;
    endtask

    task automatic wait_cnv(input int target);
        for (int i = 0; i < 3000 && cnv_cnt < target; i++) begin
            @(posedge clk); #1;
        end
        check_eq("cnv_timeout", 32'(cnv_cnt >= target), 32'd1);
    endtask

    // SPI model, scoreboard and monitor, all sampled on the falling edge
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            done = 1'b0;
            if (!rst_n) begin
                in_flight = 1'b0;
                last_done_cyc = -1;
                fin_since_done = 1'b1;
            end else begin
                if (spur_req) begin
                    done = 1'b1;
                    rd_data = 16'hFFFF;
                    spur_req = 1'b0;
                end
                if (wrt) begin
                    wrt_cnt++;
                    check_eq("wrt_while_wait", 32'(in_flight), 32'd0);
                    if (!fin_since_done && last_done_cyc >= 0)
                        check_eq("gap_cyc", 32'((cyc - last_done_cyc - 1) >= GapCyc), 32'd1);
                    if (exp_cmd_q.size() == 0) check_eq("cmd_unexp", 32'd1, 32'd0);
                    else                       check_eq("cmd", 32'(cmd), 32'(exp_cmd_q.pop_front()));
                    in_flight = 1'b1;
                    lat = 3;
                end else if (in_flight) begin
                    if (lat > 0) lat--;
                    else if (resp_q.size() > 0) begin
                        done = 1'b1;
                        rd_data = resp_q.pop_front();
                        in_flight = 1'b0;
                        last_done_cyc = cyc;
                        fin_since_done = 1'b0;
                    end
                end
                if (cnv_cmplt) begin
                    cnv_cnt++;
                    fin_since_done = 1'b1;
                    check_eq("busy_at_fin", 32'(busy), 32'd1);
                    if (exp_res_q.size() == 0) check_eq("cnv_unexp", 32'd1, 32'd0);
                    else begin
                        e = exp_res_q.pop_front();
                        check_eq("lft_ld", 32'(lft_ld), 32'(e[35:24]));
                        check_eq("rght_ld", 32'(rght_ld), 32'(e[23:12]));
                        check_eq("batt", 32'(batt), 32'(e[11:0]));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int nwr;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_lft", 32'(lft_ld), 32'd0);
        check_eq("rst_rght", 32'(rght_ld), 32'd0);
        check_eq("rst_batt", 32'(batt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wrt", 32'(wrt), 32'd0);
        check_eq("rst_cmd", 32'(cmd), 32'd0);
        check_eq("rst_cnv", 32'(cnv_cmplt), 32'd0);
        rst_n = 1'b1;

        // Single sweep
        push_sweep(12'h123, 12'h456, 12'h789, 1'b1);
        pulse_nxt();
        wait_cnv(1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("single_busy_low", 32'(busy), 32'd0);
        check_eq("single_wrt_count", 32'(wrt_cnt), 32'd6);

        // Spurious done in IDLE
        w0 = wrt_cnt;
        spur_req = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("spur_lft", 32'(lft_ld), 32'h123);
        check_eq("spur_rght", 32'(rght_ld), 32'h456);
        check_eq("spur_batt", 32'(batt), 32'h789);
        check_eq("spur_busy", 32'(busy), 32'd0);
        check_eq("spur_wrt", 32'(wrt_cnt), 32'(w0));

        // Three extra nxt during a sweep: exactly one more sweep, back to back
        push_sweep(12'h321, 12'h654, 12'h987, 1'b1);
        push_sweep(12'h111, 12'h222, 12'h333, 1'b1);
        pulse_nxt();
        repeat (5) @(posedge clk);
        pulse_nxt();
        repeat (5) @(posedge clk);
        pulse_nxt();
        repeat (5) @(posedge clk);
        pulse_nxt();
        wait_cnv(2);
        check_eq("b2b_wrt", 32'(wrt), 32'd1);
        check_eq("b2b_busy", 32'(busy), 32'd1);
        check_eq("b2b_cmd", 32'(cmd), 32'h0000);
        wait_cnv(3);
        repeat (20) @(posedge clk);
        #1;
        check_eq("pend_sweep_count", 32'(cnv_cnt), 32'd3);
        check_eq("pend_busy_low", 32'(busy), 32'd0);

        // Reset while waiting for the last read of a sweep
        w0 = wrt_cnt;
        push_sweep(12'hAAA, 12'hBBB, 12'hCCC, 1'b0);
        nwr = exp_cmd_q.size();
        pulse_nxt();
        for (int i = 0; i < 2000 && wrt_cnt < w0 + nwr; i++) begin
            @(posedge clk); #1;
        end
        check_eq("abort_wrt_timeout", 32'(wrt_cnt >= w0 + nwr), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_lft", 32'(lft_ld), 32'd0);
        check_eq("abort_rght", 32'(rght_ld), 32'd0);
        check_eq("abort_batt", 32'(batt), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_wrt", 32'(wrt), 32'd0);
        check_eq("abort_cmd", 32'(cmd), 32'd0);
        check_eq("abort_cnv", 32'(cnv_cmplt), 32'd0);
        sw_cnt = 0;
        model_batt = 12'h000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        w0 = wrt_cnt;
        spur_req = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("late_done_lft", 32'(lft_ld), 32'd0);
        check_eq("late_done_rght", 32'(rght_ld), 32'd0);
        check_eq("late_done_busy", 32'(busy), 32'd0);
        check_eq("late_done_wrt", 32'(wrt_cnt), 32'(w0));
        check_eq("abort_cmd_drained", 32'(exp_cmd_q.size()), 32'd0);

        // Clean sweep after reset, then nine more
        push_sweep(12'h135, 12'h246, 12'h357, 1'b1);
        pulse_nxt();
        wait_cnv(4);
        for (int i = 0; i < 9; i++) begin
            push_sweep(12'h400 + 12'(i), 12'h500 + 12'(i), 12'h600 + 12'(i), 1'b1);
            pulse_nxt();
            wait_cnv(5 + i);
        end
        repeat (10) @(posedge clk);
        #1;
        check_eq("final_cnv_count", 32'(cnv_cnt), 32'd13);
        check_eq("final_cmd_q_empty", 32'(exp_cmd_q.size()), 32'd0);
        check_eq("final_res_q_empty", 32'(exp_res_q.size()), 32'd0);
        check_eq("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
